// File: rtl/adder_pkg.sv
// adder_pkg -- shared definitions for the multi-cycle ripple adder.
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/sum width
//   DEFAULT_SLICE : default number of bits added per RUN cycle
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_slice.sv
// adder_slice -- combinational SLICE-bit adder with carry in/out.
// Ports:
//   A, B   : SLICE-bit operands
//   C_in   : carry into bit 0
//   S      : SLICE-bit sum
//   C_out  : carry out of bit SLICE-1
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] A,
  input  logic [SLICE-1:0] B,
  input  logic             C_in,
  output logic [SLICE-1:0] S,
  output logic             C_out
);

  assign {C_out, S} = {1'b0, A} + {1'b0, B} + {{SLICE{1'b0}}, C_in};

endmodule

// File: rtl/adder_multicycle.sv
// adder_multicycle -- adds two WIDTH-bit operands plus a carry-in, SLICE bits
// per clock, reusing a single adder_slice over N = WIDTH/SLICE RUN cycles.
//
// Handshake: start is sampled at a rising edge while the FSM is in IDLE or
// DONE; operands are captured on that edge. busy is high for the N RUN cycles,
// then done pulses for exactly one cycle while S/C_out (and V) present the new
// result. start during RUN is ignored. Results hold until the next completion
// or reset.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : begin an addition
//   A, B   : WIDTH-bit operands
//   C_in   : carry into bit 0
//   busy   : high while in RUN
//   done   : one-cycle completion pulse (DONE state)
//   S      : registered WIDTH-bit sum
//   C_out  : registered carry out of bit WIDTH-1
//   V      : registered two's-complement overflow (only with ADDER_OVERFLOW_EN)
//
// Configuration macro: ADDER_OVERFLOW_EN adds the V output and its logic.
module adder_multicycle
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(N - 1);

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] psum_next;
  logic             carry_q;
  logic [CW-1:0]    k_q;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             c_sl;
  logic             last_slice;
  logic             accept;

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign last_slice = (k_q == LAST_K);
  // start is only honoured outside RUN
  assign accept     = start && (state != RUN);

  assign a_sl = a_q[k_q*SLICE +: SLICE];
  assign b_sl = b_q[k_q*SLICE +: SLICE];

  adder_slice #(.SLICE(SLICE)) u_slice (
    .A     (a_sl),
    .B     (b_sl),
    .C_in  (carry_q),
    .S     (s_sl),
    .C_out (c_sl)
  );

  // Partial sum with the current slice merged in, so the final edge can load
  // S with the complete result in one step.
  always_comb begin
    psum_next = psum_q;
    psum_next[k_q*SLICE +: SLICE] = s_sl;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_slice) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      S       <= '0;
      C_out   <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      psum_q  <= '0;
      carry_q <= C_in;
      k_q     <= '0;
    end else if (state == RUN) begin
      psum_q  <= psum_next;
      carry_q <= c_sl;
      if (last_slice) begin
        S     <= psum_next;
        C_out <= c_sl;
      end else begin
        // counter stops at N-1, never wraps mid-operation
        k_q   <= k_q + 1'b1;
      end
    end
  end

`ifdef ADDER_OVERFLOW_EN
  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  logic carry_into_msb;
  assign carry_into_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_sl[SLICE-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      V <= 1'b0;
    end else if (!accept && state == RUN && last_slice) begin
      V <= carry_into_msb ^ c_sl;
    end
  end
`endif

endmodule

// File: tb/tb_adder_multicycle.sv
// tb_adder_multicycle -- randomized and directed stimulus for adder_multicycle
// with an arithmetic reference model, an expected-result queue and a monitor
// that checks busy/done timing and the held S/C_out/V values every cycle.
module tb_adder_multicycle;

  localparam int W  = 16;
  localparam int SL = 4;
  localparam int N  = W / SL;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         C_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         C_out;
`ifdef ADDER_OVERFLOW_EN
  logic         V;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  adder_multicycle #(.WIDTH(W), .SLICE(SL)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .C_in  (C_in),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .C_out (C_out)
`ifdef ADDER_OVERFLOW_EN
    ,
    .V     (V)
`endif
  );

  // ---------------- scoreboard ----------------
  // entry = {v, c, s}
  logic [W+1:0] exp_q[$];
  int           exp_cyc[$];
  int           last_exp = -100;   // cycle on which the newest accepted op shows done
  logic [W-1:0] model_s = '0;
  logic         model_c = 1'b0;
  logic         model_v = 1'b0;
  bit           mon_en = 1'b0;
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic c);
    longint u, sv;
    logic   v;
    u  = longint'(a) + longint'(b) + longint'(c);
    sv = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    v  = (sv > 32767) || (sv < -32768);
    return {v, u[W], u[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one cycle of inputs just after the falling edge. A start is taken
  // by the DUT at edge t unless the previous op was still running through t.
  task automatic drive_cycle(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c);
    int t;
    @(negedge clk);
    #1;
    start = s;
    A     = a;
    B     = b;
    C_in  = c;
    if (s) begin
      t = cyc + 1;
      if (!(t > last_exp - N && t <= last_exp)) begin
        exp_q.push_back(ref_result(a, b, c));
        exp_cyc.push_back(t + N);
        last_exp = t + N;
      end
    end
  endtask

  task automatic drive_rand(input logic s);
    drive_cycle(s, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    exp_q.delete();
    exp_cyc.delete();
    last_exp = -100;
    model_s  = '0;
    model_c  = 1'b0;
    model_v  = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && cyc <= last_exp; i++) drive_rand(1'b0);
    if (cyc <= last_exp) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(busy), 32'((cyc >= last_exp - N) && (cyc < last_exp)));
      check("done", 32'(done), 32'(cyc == last_exp));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          {model_v, model_c, model_s} = exp_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(exp_cyc.pop_front()));
        end
      end else if (exp_cyc.size() > 0 && cyc > exp_cyc[0]) begin
        check("missing_done", 32'd0, 32'd1);
        {model_v, model_c, model_s} = exp_q.pop_front();
        void'(exp_cyc.pop_front());
      end
      check("sum", 32'(S), 32'(model_s));
      check("carry_out", 32'(C_out), 32'(model_c));
`ifdef ADDER_OVERFLOW_EN
      check("overflow", 32'(V), 32'(model_v));
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    mon_en = 1'b1;
    repeat (2) drive_rand(1'b0);

    // carry ripples through every slice
    drive_cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    wait_idle();

    // operands scrambled during RUN (drive_rand) must not matter
    drive_cycle(1'b1, 16'h1234, 16'h4321, 1'b1);
    wait_idle();

    // second start two cycles into RUN is ignored
    drive_cycle(1'b1, 16'hA5A5, 16'h5A5A, 1'b0);
    drive_rand(1'b0);
    drive_cycle(1'b1, 16'h0F0F, 16'h0F0F, 1'b1);
    wait_idle();

    // reset during RUN aborts with no done pulse
    drive_cycle(1'b1, 16'h8001, 16'h7FFF, 1'b1);
    drive_rand(1'b0);
    drive_rand(1'b0);
    do_reset();
    repeat (3) drive_rand(1'b0);

    // start held through DONE re-enters RUN immediately
    drive_cycle(1'b1, 16'h1111, 16'h2222, 1'b0);
    repeat (N + 1) drive_cycle(1'b1, 16'h00FF, 16'h0001, 1'b0);
    wait_idle();

    // signed overflow corners
    drive_cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    wait_idle();
    drive_cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    wait_idle();
    drive_cycle(1'b1, 16'h8000, 16'h8000, 1'b0);
    wait_idle();

    // random traffic, occasional reset
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else drive_rand(1'($urandom_range(0, 3) == 0));
    end
    drive_rand(1'b0);
    wait_idle();
    repeat (2) drive_rand(1'b0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // backstop so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_multicycle.md
ADDER_MULTICYCLE -- requirements
Module: adder_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of SLICE, N = WIDTH/SLICE.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit, request to begin an addition.
REQ-006 The block SHALL have port A, input, WIDTH bits, first operand.
REQ-007 The block SHALL have port B, input, WIDTH bits, second operand.
REQ-008 The block SHALL have port C_in, input, 1 bit, carry into bit 0.
REQ-009 The block SHALL have port busy, output, 1 bit, high while an addition is in progress.
REQ-010 The block SHALL have port done, output, 1 bit, one-cycle pulse marking S/C_out valid.
REQ-011 The block SHALL have port S, output, WIDTH bits, registered sum.
REQ-012 The block SHALL have port C_out, output, 1 bit, registered carry out of bit WIDTH-1.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL capture A, B and C_in into internal registers, clear the slice counter, and enter RUN.
REQ-015 In RUN, each edge SHALL add operand slice k (bits k*SLICE+SLICE-1 .. k*SLICE) plus the carry register, store the slice result in a partial-sum register, update the carry register, and increment k.
REQ-016 On the RUN edge where k = N-1, the FSM SHALL load S from the completed partial sum, load C_out from the final carry, and enter DONE.
REQ-017 done SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL go to IDLE unless start=1, which goes to RUN per REQ-014.
REQ-018 busy SHALL be 1 exactly while in RUN.
REQ-019 Latency: with start sampled at edge t, done SHALL be high during the cycle after edge t+N; default N=4.
REQ-020 start SHALL be ignored while in RUN; A, B and C_in changes during RUN SHALL NOT affect the result.
REQ-021 S and C_out SHALL change only on the final RUN edge and SHALL hold their values until the next completion or reset.
REQ-022 The result SHALL equal (A + B + C_in) mod 2^WIDTH in S, with the carry-out bit in C_out.
REQ-023 The slice counter SHALL be ceil(log2(N)) bits wide, minimum 1, and SHALL NOT wrap within an operation.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear busy, done, S, C_out, the operand, carry and partial-sum registers, and the counter.
REQ-025 rst SHALL take priority over start; reset in RUN SHALL abort the operation with no done pulse.

Configuration
REQ-026 With ADDER_OVERFLOW_EN defined, the block SHALL have an output port V, 1 bit, two's-complement overflow, computed as the carry into bit WIDTH-1 XOR C_out.
REQ-027 V SHALL be registered with S, cleared by reset, and held like S.
REQ-028 Without ADDER_OVERFLOW_EN, port V and its logic SHALL be absent.

Structure
REQ-029 Package adder_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default WIDTH/SLICE constants.
REQ-030 Sub-module adder_slice SHALL implement a combinational SLICE-bit adder (A, B, C_in -> S, C_out) instantiated once and reused every RUN cycle.

Verification
REQ-031 Start with A=16'hFFFF, B=16'h0001, C_in=0 -> busy for 4 cycles, then done pulse, S=16'h0000, C_out=1.
REQ-032 Start with A=16'h1234, B=16'h4321, C_in=1 -> S=16'h5556, C_out=0; A/B changed mid-RUN do not alter the result.
REQ-033 Pulse start again 2 cycles into RUN -> ignored; exactly one done pulse, 4 cycles after the first start.
REQ-034 Assert rst at the third RUN cycle -> next cycle busy=0, done=0, S=0, C_out=0, no done pulse.
REQ-035 Hold start=1 through DONE with new operands 16'h00FF + 16'h0001 -> RUN re-entered immediately; second result is S=16'h0100.
REQ-036 With ADDER_OVERFLOW_EN, 16'h7FFF + 16'h0001 -> V=1, S=16'h8000; 16'hFFFF + 16'h0001 -> V=0.
